// File: rtl/cpu_types_pkg.sv
// Shared CPU types: 32-bit word, fetch FSM states and the PC increment helper.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN,
    PEND,
    HALTED
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

  // Wraps modulo 2^32, so the top word of memory falls through to address 0.
  function automatic word_t pc_next(input word_t pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of the fetch-stage signals, with one view for the fetch unit and one for its driver.
interface fetch_if
  import cpu_types_pkg::*;
(
  input logic CLK
);
  logic  RST;
  logic  ihit;
  word_t imemload;
  word_t imemaddr;
  logic  imemREN;
  logic  freeze;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  word_t instr_o;
  word_t next_pc_o;
  logic  valid_o;
  logic  flush_o;
  word_t fetch_cnt;

  modport fu (
    input  CLK, RST, ihit, imemload, freeze, redirect, redirect_pc, halt,
    output imemaddr, imemREN, instr_o, next_pc_o, valid_o, flush_o, fetch_cnt
  );

  modport tb (
    input  CLK, imemaddr, imemREN, instr_o, next_pc_o, valid_o, flush_o, fetch_cnt,
    output RST, ihit, imemload, freeze, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues I-memory reads, and defers redirects
// that land during a miss so the fetch address never moves mid-fill.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  word_t imemload,
  output word_t imemaddr,
  output logic  imemREN,
  input  logic  freeze,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  halt,
  output word_t instr_o,
  output word_t next_pc_o,
  output logic  valid_o,
  output logic  flush_o,
  output word_t fetch_cnt
);

  fetch_state_t state;
  word_t        pc;
  word_t        pend_pc;
  word_t        cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= RUN;
      pc      <= PC_INIT;
      pend_pc <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        RUN: begin
          if (halt) begin
            state <= HALTED;
          end else if (redirect) begin
            if (ihit) begin
              pc <= redirect_pc;
            end else begin
              pend_pc <= redirect_pc;
              state   <= PEND;
            end
          end else if (ihit && !freeze) begin
            pc  <= pc_next(pc);
            cnt <= cnt + 32'd1;
          end
        end
        PEND: begin
          // The newest redirect wins, even one arriving on the completing hit.
          if (halt) begin
            state <= HALTED;
          end else if (ihit) begin
            pc    <= redirect ? redirect_pc : pend_pc;
            state <= RUN;
          end else if (redirect) begin
            pend_pc <= redirect_pc;
          end
        end
        HALTED: state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  assign imemaddr  = pc;
  assign imemREN   = (state != HALTED);
  assign instr_o   = imemload;
  assign next_pc_o = pc_next(pc);
  assign valid_o   = ~RST & ihit & ~freeze & ~redirect & (state == RUN);
  assign flush_o   = ~RST & redirect & (state != HALTED);
  assign fetch_cnt = cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  localparam word_t INIT = 32'h0000_0200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  fetch_if bus (.CLK(clk));

  fetch_unit #(.PC_INIT(INIT)) dut (
    .CLK        (clk),
    .RST        (bus.RST),
    .ihit       (bus.ihit),
    .imemload   (bus.imemload),
    .imemaddr   (bus.imemaddr),
    .imemREN    (bus.imemREN),
    .freeze     (bus.freeze),
    .redirect   (bus.redirect),
    .redirect_pc(bus.redirect_pc),
    .halt       (bus.halt),
    .instr_o    (bus.instr_o),
    .next_pc_o  (bus.next_pc_o),
    .valid_o    (bus.valid_o),
    .flush_o    (bus.flush_o),
    .fetch_cnt  (bus.fetch_cnt)
  );

  typedef struct {
    word_t addr;
    logic  ren;
    word_t instr;
    word_t npc;
    logic  valid;
    logic  flush;
    word_t cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Behavioural model: where fetching is, where it will jump, how much was delivered.
  word_t m_pc;
  word_t m_target;
  word_t m_cnt;
  bit    m_halted;
  bit    m_pending;

  task automatic chk(input string name, input word_t act, input word_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input bit rs, input bit ih, input bit fr, input bit rd,
                       input word_t rp, input bit hl);
    exp_t e;
    bus.RST         = rs;
    bus.ihit        = ih;
    bus.freeze      = fr;
    bus.redirect    = rd;
    bus.redirect_pc = rp;
    bus.halt        = hl;
    bus.imemload    = $urandom;
    if (rs) begin
      m_pc = INIT; m_target = '0; m_cnt = '0; m_halted = 0; m_pending = 0;
    end
    e.addr  = m_pc;
    e.ren   = !m_halted;
    e.instr = bus.imemload;
    e.npc   = m_pc + 32'd4;
    e.valid = !rs && ih && !fr && !rd && !m_halted && !m_pending;
    e.flush = !rs && rd && !m_halted;
    e.cnt   = m_cnt;
    q.push_back(e);
    if (!rs && !m_halted) begin
      if (hl) begin
        m_halted = 1; m_pending = 0;
      end else if (m_pending) begin
        if (rd) m_target = rp;
        if (ih) begin m_pc = m_target; m_pending = 0; end
      end else if (rd) begin
        if (ih) m_pc = rp;
        else begin m_target = rp; m_pending = 1; end
      end else if (ih && !fr) begin
        m_pc = m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("imemaddr",  bus.imemaddr,       e.addr);
        chk("imemREN",   32'(bus.imemREN),   32'(e.ren));
        chk("instr_o",   bus.instr_o,        e.instr);
        chk("next_pc_o", bus.next_pc_o,      e.npc);
        chk("valid_o",   32'(bus.valid_o),   32'(e.valid));
        chk("flush_o",   32'(bus.flush_o),   32'(e.flush));
        chk("fetch_cnt", bus.fetch_cnt,      e.cnt);
      end
    end
  end

  initial begin
    bit ih, fr, rd, hl, rs;
    bus.RST = 1; bus.ihit = 0; bus.freeze = 0; bus.redirect = 0;
    bus.redirect_pc = '0; bus.halt = 0; bus.imemload = '0;
    @(posedge clk);
    #1;

    drive(1, 0, 0, 0, '0, 0);
    chk("reset_addr", bus.imemaddr, 32'h200);
    repeat (4) drive(0, 1, 0, 0, '0, 0);
    chk("stream_cnt", bus.fetch_cnt, 32'd4);
    chk("stream_addr", bus.imemaddr, 32'h210);

    drive(0, 1, 0, 1, 32'h40, 0);
    repeat (3) drive(0, 1, 1, 0, '0, 0);
    chk("freeze_addr", bus.imemaddr, 32'h40);
    chk("freeze_cnt", bus.fetch_cnt, 32'd4);
    drive(0, 1, 0, 0, '0, 0);
    chk("unfreeze_addr", bus.imemaddr, 32'h44);

    drive(0, 1, 0, 1, 32'h40, 0);
    drive(0, 1, 0, 1, 32'h100, 0);
    chk("redir_hit_addr", bus.imemaddr, 32'h100);

    drive(0, 1, 0, 1, 32'h40, 0);
    drive(0, 0, 0, 1, 32'h100, 0);
    drive(0, 0, 0, 0, '0, 0);
    drive(0, 0, 0, 1, 32'h180, 0);
    drive(0, 0, 0, 0, '0, 0);
    chk("pend_hold_addr", bus.imemaddr, 32'h40);
    drive(0, 1, 0, 0, '0, 0);
    chk("pend_target_addr", bus.imemaddr, 32'h180);

    drive(0, 1, 0, 1, 32'hFFFF_FFFC, 0);
    chk("wrap_next_pc", bus.next_pc_o, 32'h0);
    drive(0, 1, 0, 0, '0, 0);
    chk("wrap_addr", bus.imemaddr, 32'h0);

    drive(0, 1, 0, 1, 32'h80, 0);
    drive(0, 1, 0, 1, 32'h300, 1);
    chk("halt_ren", 32'(bus.imemREN), 32'd0);
    repeat (3) drive(0, 1, 0, 1, 32'h400, 0);
    chk("halt_addr", bus.imemaddr, 32'h80);
    chk("halt_flush", 32'(bus.flush_o), 32'd0);

    drive(1, 0, 0, 0, '0, 0);
    drive(0, 0, 0, 1, 32'h100, 0);
    drive(1, 0, 0, 0, '0, 0);
    chk("rst_pend_addr", bus.imemaddr, 32'h200);
    drive(0, 1, 0, 0, '0, 0);
    chk("rst_pend_drop", bus.imemaddr, 32'h204);

    for (int i = 0; i < 800; i++) begin
      rs = m_halted ? ($urandom_range(99) < 15) : ($urandom_range(99) < 2);
      ih = $urandom_range(99) < 65;
      fr = $urandom_range(99) < 20;
      rd = $urandom_range(99) < 15;
      hl = $urandom_range(99) < 2;
      drive(rs, ih, fr, rd, {$urandom_range(32'h3FFF_FFFF), 2'b00}, hl);
    end

    drive(0, 0, 0, 0, '0, 0);
    chk("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that owns the program counter and drives the instruction-memory request. It sits directly upstream of the IF/ID pipeline latch, feeding it `instr_o`, `next_pc_o` and `flush_o`. It also absorbs downstream freezes, branch/jump redirects and halt. Redirects that arrive during an outstanding I-cache miss are held until the miss completes, so the memory address never changes mid-fill.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- ihit  input  1  instruction memory returns valid data this cycle.
- imemload  input  32  instruction word from memory.
- imemaddr  output  32  fetch address; equals PC.
- imemREN  output  1  fetch request enable.
- freeze  input  1  downstream hazard stall; hold PC.
- redirect  input  1  resolved branch/jump; take redirect_pc.
- redirect_pc  input  32  redirect target, word aligned.
- halt  input  1  halt seen downstream; stop fetching.
- instr_o  output  32  fetched instruction to IF/ID.
- next_pc_o  output  32  PC+4 to IF/ID.
- valid_o  output  1  instr_o is a good instruction this cycle.
- flush_o  output  1  squash IF/ID contents.
- fetch_cnt  output  32  count of delivered instructions.

Behaviour:
- Reset (async, RST=1):
  - pc=PC_INIT, state=RUN, pend_pc=0, fetch_cnt=0.
  - Outputs: imemREN=1, valid_o=0, flush_o=0, instr_o=imemload (pass-through), next_pc_o=PC_INIT+4.
  - RST mid-miss or while in PEND discards the pending redirect.
- States: RUN, PEND (redirect latched, waiting for ihit), HALTED.
- Combinational outputs:
  - imemaddr=pc.
  - imemREN = (state!=HALTED).
  - instr_o=imemload.
  - next_pc_o=pc+4, modulo 2^32 (32'hFFFF_FFFC+4 = 0).
  - valid_o = ihit & ~freeze & ~redirect & (state==RUN).
  - flush_o = redirect & (state!=HALTED).
- RUN:
  - halt=1 → HALTED next cycle; pc holds. Halt beats every other input.
  - redirect=1 & ihit=1 → pc<=redirect_pc. The fetched instruction is dropped (valid_o=0).
  - redirect=1 & ihit=0 → pend_pc<=redirect_pc, go to PEND; pc holds.
  - ihit=1 & freeze=1 → pc holds (redirect has priority over freeze).
  - ihit=1 & freeze=0 → pc<=pc+4, fetch_cnt++ (wraps at 2^32).
  - ihit=0 → pc holds.
- PEND:
  - imemaddr stays at the old pc until ihit.
  - Another redirect overwrites pend_pc; the newest target wins.
  - ihit=1 → pc<=pend_pc (or redirect_pc if redirect is asserted the same cycle), go to RUN. The returned word is discarded (valid_o=0).
  - halt=1 → HALTED; the pending redirect is dropped.
- HALTED:
  - Sticky until RST.
  - imemREN=0, valid_o=0, flush_o=0; all other inputs are ignored.
- Latency: one instruction per cycle when ihit=1 continuously. Redirect-to-target-fetch is 1 cycle if ihit, otherwise miss latency + 1.
- redirect_pc[1:0] is not checked; the caller guarantees alignment.

Decomposition:
- Add to cpu_types_pkg:
  - `fetch_state_t` enum {RUN, PEND, HALTED}.
  - `PC_STEP` = 32'd4.
- Reuse `word_t` for all 32-bit buses.
- No sub-module; PC register, pend register and FSM stay in a single module.
- Add `fetch_if` interface with modports `fu` and `tb` mirroring the port list.

Test Plan:
- Reset with PC_INIT=32'h0000_0200, ihit=1 for 4 cycles → imemaddr 200,204,208,20C; valid_o=1 each cycle; fetch_cnt=4.
- pc=0x40, ihit=1, freeze=1 for 3 cycles → imemaddr stays 0x40, valid_o=0, fetch_cnt unchanged; freeze drops → pc=0x44 next cycle.
- pc=0x40, ihit=1, redirect=1, redirect_pc=0x100 → flush_o=1, valid_o=0, next imemaddr=0x100.
- pc=0x40, ihit=0, redirect to 0x100, then redirect to 0x180 two cycles later, ihit=1 after 5 cycles:
  - imemaddr holds 0x40 throughout; that ihit cycle has valid_o=0.
  - Next cycle imemaddr=0x180, state=RUN.
- halt=1 and redirect=1 in the same cycle at pc=0x80 → HALTED; imemREN=0 and pc=0x80 thereafter; flush_o=0 from the next cycle on; only RST recovers.
- pc=32'hFFFF_FFFC, ihit=1 → next imemaddr=0, next_pc_o was 0. Also assert RST while in PEND → pc=PC_INIT, pending target discarded.
